// File: rtl/fetch_controller.sv
// fetch_controller: walks the pc through fetch and issue, runs the imem
// req/ack handshake, holds the fetched word in ir and offers it to execute.
// Ports:
//   clk, reset (async, active-low)
//   pc_out -> pc_inc / pc_load / pc_reset / pc_in : pc control
//   imem_req / imem_addr -> imem_ack / imem_rdata : instruction fetch
//   ir / ir_valid -> exec_ready / branch_taken / branch_target : issue
//   halt : stop fetching at the next accept
//   fault : fetch timeout, sticky until reset
module fetch_controller #(
    parameter int DW          = 16,
    parameter int AW          = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc_out,
    output logic          pc_inc,
    output logic          pc_load,
    output logic          pc_reset,
    output logic [AW-1:0] pc_in,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] ir,
    output logic          ir_valid,
    input  logic          exec_ready,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,
    input  logic          halt,
    output logic          fault
);

    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        PCRST,
        FETCH,
        ISSUE,
        HALTED,
        FAULT
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   ir_q;
    logic            pcrst_q;
    logic            req_q;
    logic            valid_q;
    logic            fault_q;

    logic            accept;

    assign accept = valid_q & exec_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PCRST;
            cnt_q   <= '0;
            ir_q    <= '0;
            pcrst_q <= 1'b1;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                PCRST: begin
                    state_q <= FETCH;
                    pcrst_q <= 1'b0;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    // An ack on the last allowed cycle still completes.
                    if (imem_ack) begin
                        state_q <= ISSUE;
                        ir_q    <= imem_rdata;
                        cnt_q   <= '0;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= FAULT;
                        cnt_q   <= '0;
                        req_q   <= 1'b0;
                        fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_ready) begin
                        valid_q <= 1'b0;
                        if (halt) begin
                            state_q <= HALTED;
                        end else begin
                            state_q <= FETCH;
                            req_q   <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state_q <= FETCH;
                        req_q   <= 1'b1;
                    end
                end
                FAULT: begin
                    state_q <= FAULT;
                end
                default: begin
                    state_q <= PCRST;
                    cnt_q   <= '0;
                    pcrst_q <= 1'b1;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    fault_q <= 1'b0;
                end
            endcase
        end
    end

    // pc strobes are Mealy on the accepting cycle; the rest are flops.
    assign pc_inc    = accept & ~branch_taken;
    assign pc_load   = accept & branch_taken;
    assign pc_in     = pc_load ? branch_target : '0;
    assign pc_reset  = pcrst_q;

    assign imem_req  = req_q;
    assign imem_addr = pc_out;

    assign ir        = ir_q;
    assign ir_valid  = valid_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed vectors for fetch_controller with a
// behavioural pc model; expected values are hand-derived.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_out;
    logic        pc_inc;
    logic        pc_load;
    logic        pc_reset;
    logic [15:0] pc_in;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        exec_ready;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        halt;
    logic        fault;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] pc_q;

    fetch_controller #(
        .DW(16),
        .AW(16),
        .MEM_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc_out(pc_out),
        .pc_inc(pc_inc),
        .pc_load(pc_load),
        .pc_reset(pc_reset),
        .pc_in(pc_in),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .ir(ir),
        .ir_valid(ir_valid),
        .exec_ready(exec_ready),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .halt(halt),
        .fault(fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset)       pc_q <= 16'h0000;
        else if (pc_reset) pc_q <= 16'h0000;
        else if (pc_load)  pc_q <= pc_in;
        else if (pc_inc)   pc_q <= pc_q + 16'h0001;
    end

    assign pc_out = pc_q;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [15:0] addr);
        check({tag, ".req"}, 32'(imem_req), 32'd1);
        check({tag, ".addr"}, 32'(imem_addr), 32'(addr));
        check({tag, ".irv"}, 32'(ir_valid), 32'd0);
        check({tag, ".strb"}, {29'd0, pc_inc, pc_load, pc_reset}, 32'd0);
    endtask

    task automatic chk_strb(input string tag, input logic [2:0] exp);
        check({tag, ".strb"}, {29'd0, pc_inc, pc_load, pc_reset}, 32'(exp));
    endtask

    initial begin
        reset         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 16'h0000;
        exec_ready    = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        halt          = 1'b0;

        // reset state
        tick;
        tick;
        #1;
        chk_strb("rst", 3'b001);
        check("rst.req", 32'(imem_req), 32'd0);
        check("rst.ir", 32'(ir), 32'd0);
        check("rst.irv", 32'(ir_valid), 32'd0);
        check("rst.fault", 32'(fault), 32'd0);
        check("rst.pcin", 32'(pc_in), 32'd0);

        reset = 1'b1;
        #1;
        chk_strb("rel", 3'b001);
        check("rel.req", 32'(imem_req), 32'd0);
        tick;

        // 1: back-to-back, same-cycle ack, 2 cycles per instruction
        exec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'h1000 + 16'(i);
            #1;
            chk_fetch("t1.f", 16'(i));
            tick;
            imem_ack = 1'b0;
            #1;
            check("t1.irv", 32'(ir_valid), 32'd1);
            check("t1.ir", 32'(ir), 32'h1000 + 32'(i));
            check("t1.req", 32'(imem_req), 32'd0);
            chk_strb("t1.i", 3'b100);
            check("t1.pcin", 32'(pc_in), 32'd0);
            tick;
        end

        // 3: branch to 0x0040, then branch to 5
        imem_ack   = 1'b1;
        imem_rdata = 16'h2000;
        #1;
        chk_fetch("t3.f", 16'h0004);
        tick;
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h0040;
        #1;
        chk_strb("t3.br", 3'b010);
        check("t3.pcin", 32'(pc_in), 32'h0040);
        tick;
        branch_taken = 1'b0;
        imem_ack     = 1'b1;
        imem_rdata   = 16'h3000;
        #1;
        chk_fetch("t3.tgt", 16'h0040);
        tick;
        imem_ack      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 16'h0005;
        #1;
        chk_strb("t3.br5", 3'b010);
        check("t3.pcin5", 32'(pc_in), 32'h0005);
        tick;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;

        // 2: three wait cycles, then ack with A5A5
        for (int k = 0; k < 4; k++) begin
            imem_ack   = (k == 3);
            imem_rdata = (k == 3) ? 16'hA5A5 : 16'h0000;
            #1;
            chk_fetch("t2.f", 16'h0005);
            tick;
        end
        imem_ack   = 1'b0;
        exec_ready = 1'b0;

        // 4: execute stalls five cycles
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4.irv", 32'(ir_valid), 32'd1);
            check("t4.ir", 32'(ir), 32'hA5A5);
            chk_strb("t4.s", 3'b000);
            tick;
        end
        exec_ready = 1'b1;
        #1;
        chk_strb("t4.acc", 3'b100);
        tick;
        exec_ready = 1'b0;

        // 5: ack never comes
        for (int k = 0; k < 15; k++) begin
            #1;
            chk_fetch("t5.f", 16'h0006);
            check("t5.flt", 32'(fault), 32'd0);
            tick;
        end
        imem_ack   = 1'b1;
        exec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t5.fault", 32'(fault), 32'd1);
            check("t5.req", 32'(imem_req), 32'd0);
            check("t5.irv", 32'(ir_valid), 32'd0);
            chk_strb("t5.s", 3'b000);
            tick;
        end
        imem_ack = 1'b0;

        // 6: reset clears fault
        reset = 1'b0;
        #1;
        check("t6.flt", 32'(fault), 32'd0);
        check("t6.req", 32'(imem_req), 32'd0);
        chk_strb("t6.r", 3'b001);
        tick;
        reset = 1'b1;
        #1;
        tick;

        // ack on the 15th request cycle still completes
        for (int k = 0; k < 15; k++) begin
            imem_ack   = (k == 14);
            imem_rdata = 16'h5A5A;
            #1;
            chk_fetch("t6.b", 16'h0000);
            tick;
        end
        imem_ack = 1'b0;
        #1;
        check("t6.bflt", 32'(fault), 32'd0);
        check("t6.birv", 32'(ir_valid), 32'd1);
        check("t6.bir", 32'(ir), 32'h5A5A);
        chk_strb("t6.bi", 3'b100);
        tick;

        // reset mid-handshake
        for (int k = 0; k < 2; k++) begin
            #1;
            chk_fetch("t6.m", 16'h0001);
            tick;
        end
        reset = 1'b0;
        #1;
        check("t6.mreq", 32'(imem_req), 32'd0);
        check("t6.mir", 32'(ir), 32'd0);
        check("t6.mirv", 32'(ir_valid), 32'd0);
        chk_strb("t6.mr", 3'b001);
        tick;
        reset = 1'b1;
        #1;
        tick;

        // halt during fetch finishes the fetch and accept, then parks
        halt = 1'b1;
        #1;
        chk_fetch("t6.h0", 16'h0000);
        tick;
        imem_ack   = 1'b1;
        imem_rdata = 16'h7777;
        #1;
        chk_fetch("t6.h1", 16'h0000);
        tick;
        imem_ack = 1'b0;
        #1;
        check("t6.hir", 32'(ir), 32'h7777);
        check("t6.hirv", 32'(ir_valid), 32'd1);
        chk_strb("t6.hi", 3'b100);
        tick;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t6.hreq", 32'(imem_req), 32'd0);
            check("t6.hv", 32'(ir_valid), 32'd0);
            chk_strb("t6.hs", 3'b000);
            tick;
        end
        halt = 1'b0;
        #1;
        check("t6.hl", 32'(imem_req), 32'd0);
        tick;
        #1;
        chk_fetch("t6.res", 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
